// File: rtl/time_set_controller.sv
// Front-panel time-setting controller: steps through hour/minute/second edit fields.
// Optional auto-repeat on held inc/dec is enabled by defining TIME_SET_AUTO_REPEAT_EN.
module time_set_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY   = 500000,
   parameter int unsigned REPEAT_PERIOD  = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_minute,
   input  logic [5:0] cur_second,
   output logic       set_time_en,
   output logic [4:0] set_time_hour,
   output logic [5:0] set_time_minute,
   output logic [5:0] set_time_second,
   output logic [1:0] edit_field
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   // Encoding doubles as the edit_field value.
   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StSetHour   = 2'd1,
      StSetMinute = 2'd2,
      StSetSecond = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            mode_hist_q, inc_hist_q, dec_hist_q;
   logic [4:0]      hour_q, hour_d;
   logic [5:0]      minute_q, minute_d;
   logic [5:0]      second_q, second_d;
   logic            en_q, en_d;
   logic [1:0]      field_q, field_d;

   logic mode_edge, inc_edge, dec_edge, any_edge, in_set;
   logic edge_up, edge_dn, step_up, step_dn;
   logic rpt_fire, rpt_step_up, rpt_step_dn;

   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
      return (v >= top) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
      return ((v == 6'd0) || (v > top)) ? top : v - 6'd1;
   endfunction

   always_comb begin
      mode_edge = btn_mode & ~mode_hist_q;
      inc_edge  = btn_inc & ~inc_hist_q;
      dec_edge  = btn_dec & ~dec_hist_q;
      any_edge  = mode_edge | inc_edge | dec_edge;
      in_set    = (state_q != StIdle);
      // Simultaneous inc/dec cancel; mode has priority over both.
      edge_up   = in_set & inc_edge & ~dec_edge & ~mode_edge;
      edge_dn   = in_set & dec_edge & ~inc_edge & ~mode_edge;
   end

`ifdef TIME_SET_AUTO_REPEAT_EN
   logic        rpt_active_q, rpt_active_d;
   logic        rpt_up_q, rpt_up_d;
   logic        rpt_period_q, rpt_period_d;
   logic [31:0] rpt_cnt_q, rpt_cnt_d;
   logic [31:0] rpt_target;
   logic        rpt_held;

   always_comb begin
      rpt_held    = rpt_up_q ? (btn_inc & ~btn_dec) : (btn_dec & ~btn_inc);
      rpt_target  = rpt_period_q ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1);
      rpt_fire    = rpt_active_q & rpt_held & in_set & ~mode_edge & (rpt_cnt_q == rpt_target);
      rpt_step_up = rpt_fire & rpt_up_q;
      rpt_step_dn = rpt_fire & ~rpt_up_q;
   end

   always_comb begin
      rpt_active_d = rpt_active_q;
      rpt_up_d     = rpt_up_q;
      rpt_period_d = rpt_period_q;
      rpt_cnt_d    = rpt_cnt_q;
      if (edge_up || edge_dn) begin
         rpt_active_d = 1'b1;
         rpt_up_d     = edge_up;
         rpt_period_d = 1'b0;
         rpt_cnt_d    = '0;
      end else if (!rpt_active_q || !rpt_held || mode_edge || (state_d != state_q)) begin
         rpt_active_d = 1'b0;
         rpt_period_d = 1'b0;
         rpt_cnt_d    = '0;
      end else if (rpt_fire) begin
         rpt_period_d = 1'b1;
         rpt_cnt_d    = '0;
      end else begin
         rpt_cnt_d = rpt_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_active_q <= 1'b0;
         rpt_up_q     <= 1'b0;
         rpt_period_q <= 1'b0;
         rpt_cnt_q    <= '0;
      end else begin
         rpt_active_q <= rpt_active_d;
         rpt_up_q     <= rpt_up_d;
         rpt_period_q <= rpt_period_d;
         rpt_cnt_q    <= rpt_cnt_d;
      end
   end
`else
   logic unused_rpt_params;
   assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};

   always_comb begin
      rpt_fire    = 1'b0;
      rpt_step_up = 1'b0;
      rpt_step_dn = 1'b0;
   end
`endif

   always_comb begin
      state_d  = state_q;
      tmo_d    = tmo_q;
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      step_up  = edge_up | rpt_step_up;
      step_dn  = edge_dn | rpt_step_dn;

      unique case (state_q)
         StIdle: begin
            tmo_d = '0;
            if (mode_edge) begin
               state_d  = StSetHour;
               hour_d   = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
               minute_d = (cur_minute > 6'd59) ? 6'd0 : cur_minute;
               second_d = (cur_second > 6'd59) ? 6'd0 : cur_second;
            end
         end
         StSetHour:   if (mode_edge) state_d = StSetMinute;
         StSetMinute: if (mode_edge) state_d = StSetSecond;
         StSetSecond: if (mode_edge) state_d = StIdle;
      endcase

      // Any button activity (or a repeat step) keeps the edit alive.
      if (in_set) begin
         if (any_edge || rpt_fire) begin
            tmo_d = '0;
         end else if (tmo_q == TmoLast) begin
            state_d = StIdle;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + TmoW'(1);
         end
      end

      if (step_up) begin
         unique case (state_q)
            StSetHour:   hour_d   = 5'(wrap_inc({1'b0, hour_q}, 6'd23));
            StSetMinute: minute_d = wrap_inc(minute_q, 6'd59);
            StSetSecond: second_d = wrap_inc(second_q, 6'd59);
            StIdle:      ;
         endcase
      end else if (step_dn) begin
         unique case (state_q)
            StSetHour:   hour_d   = 5'(wrap_dec({1'b0, hour_q}, 6'd23));
            StSetMinute: minute_d = wrap_dec(minute_q, 6'd59);
            StSetSecond: second_d = wrap_dec(second_q, 6'd59);
            StIdle:      ;
         endcase
      end

      en_d    = (state_d != StIdle);
      field_d = state_d;
   end

   // History resets high so a button held through reset does not register as a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         tmo_q       <= '0;
         mode_hist_q <= 1'b1;
         inc_hist_q  <= 1'b1;
         dec_hist_q  <= 1'b1;
         hour_q      <= '0;
         minute_q    <= '0;
         second_q    <= '0;
         en_q        <= 1'b0;
         field_q     <= '0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         mode_hist_q <= btn_mode;
         inc_hist_q  <= btn_inc;
         dec_hist_q  <= btn_dec;
         hour_q      <= hour_d;
         minute_q    <= minute_d;
         second_q    <= second_d;
         en_q        <= en_d;
         field_q     <= field_d;
      end
   end

   assign set_time_en     = en_q;
   assign set_time_hour   = hour_q;
   assign set_time_minute = minute_q;
   assign set_time_second = second_q;
   assign edit_field      = field_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: vector table plus multi-cycle sequences.
// Expectations for the held-button sequence depend on TIME_SET_AUTO_REPEAT_EN.
module tb_time_set_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_mode, btn_inc, btn_dec;
   logic [4:0] cur_hour;
   logic [5:0] cur_minute, cur_second;
   logic       set_time_en;
   logic [4:0] set_time_hour;
   logic [5:0] set_time_minute, set_time_second;
   logic [1:0] edit_field;

   int checks   = 0;
   int failures = 0;

   time_set_controller #(
      .TIMEOUT_CYCLES(16),
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .btn_mode       (btn_mode),
      .btn_inc        (btn_inc),
      .btn_dec        (btn_dec),
      .cur_hour       (cur_hour),
      .cur_minute     (cur_minute),
      .cur_second     (cur_second),
      .set_time_en    (set_time_en),
      .set_time_hour  (set_time_hour),
      .set_time_minute(set_time_minute),
      .set_time_second(set_time_second),
      .edit_field     (edit_field)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       m, i, d;
      logic [4:0] ch;
      logic [5:0] cm, cs;
      logic       en;
      logic [1:0] f;
      logic [4:0] h;
      logic [5:0] mi, s;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic m, input logic i, input logic d,
                      input int ch, input int cm, input int cs,
                      input logic en, input int f, input int h, input int mi, input int s);
      vec_t v;
      v.m = m; v.i = i; v.d = d;
      v.ch = 5'(ch); v.cm = 6'(cm); v.cs = 6'(cs);
      v.en = en; v.f = 2'(f); v.h = 5'(h); v.mi = 6'(mi); v.s = 6'(s);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk_all(input string name, input int idx, input logic en, input int f,
                          input int h, input int mi, input int s);
      chk({name, ".en"}, idx, int'(set_time_en), int'(en));
      chk({name, ".field"}, idx, int'(edit_field), f);
      chk({name, ".hour"}, idx, int'(set_time_hour), h);
      chk({name, ".min"}, idx, int'(set_time_minute), mi);
      chk({name, ".sec"}, idx, int'(set_time_second), s);
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      tick();
      btn_mode = 1'b0;
      tick();
   endtask

   // Waits (bounded) for the edit to be abandoned; an expired bound is reported.
   task automatic wait_idle(input int idx);
      int n = 0;
      while (set_time_en && n < 40) begin
         tick();
         n++;
      end
      chk("wait_idle", idx, int'(set_time_en), 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      btn_mode   = 1'b1;
      btn_inc    = 1'b0;
      btn_dec    = 1'b0;
      cur_hour   = 5'd12;
      cur_minute = 6'd34;
      cur_second = 6'd56;

      //  m  i  d  ch  cm  cs   en f  h   mi  s
      add(1, 0, 0, 12, 34, 56,  0, 0, 0,  0,  0);   // mode held through reset: no edge
      add(0, 0, 0, 12, 34, 56,  0, 0, 0,  0,  0);
      add(1, 0, 0, 12, 34, 56,  1, 1, 12, 34, 56);  // enter hour, preload
      add(0, 0, 0, 12, 34, 56,  1, 1, 12, 34, 56);
      add(0, 1, 0, 12, 34, 56,  1, 1, 13, 34, 56);
      add(0, 0, 0, 12, 34, 56,  1, 1, 13, 34, 56);
      add(1, 0, 0, 12, 34, 56,  1, 2, 13, 34, 56);
      add(0, 0, 0, 12, 34, 56,  1, 2, 13, 34, 56);
      add(0, 0, 1, 12, 34, 56,  1, 2, 13, 33, 56);
      add(0, 0, 0, 12, 34, 56,  1, 2, 13, 33, 56);
      add(1, 0, 0, 12, 34, 56,  1, 3, 13, 33, 56);
      add(0, 0, 0, 12, 34, 56,  1, 3, 13, 33, 56);
      add(0, 1, 0, 12, 34, 56,  1, 3, 13, 33, 57);
      add(0, 0, 0, 12, 34, 56,  1, 3, 13, 33, 57);
      add(1, 0, 0, 12, 34, 56,  0, 0, 13, 33, 57);  // back to idle, values held
      add(0, 0, 0, 23, 0,  45,  0, 0, 13, 33, 57);
      add(0, 1, 0, 23, 0,  45,  0, 0, 13, 33, 57);  // inc in idle ignored
      add(0, 0, 0, 23, 0,  45,  0, 0, 13, 33, 57);
      add(1, 0, 0, 23, 0,  45,  1, 1, 23, 0,  45);
      add(0, 0, 0, 23, 0,  45,  1, 1, 23, 0,  45);
      add(0, 1, 0, 23, 0,  45,  1, 1, 0,  0,  45);  // hour 23 -> 0
      add(0, 0, 0, 23, 0,  45,  1, 1, 0,  0,  45);
      add(0, 0, 1, 23, 0,  45,  1, 1, 23, 0,  45);  // hour 0 -> 23
      add(0, 0, 0, 23, 0,  45,  1, 1, 23, 0,  45);
      add(1, 0, 0, 23, 0,  45,  1, 2, 23, 0,  45);
      add(0, 0, 0, 23, 0,  45,  1, 2, 23, 0,  45);
      add(0, 0, 1, 23, 0,  45,  1, 2, 23, 59, 45);  // minute 0 -> 59
      add(0, 0, 0, 23, 0,  45,  1, 2, 23, 59, 45);
      add(0, 1, 1, 23, 0,  45,  1, 2, 23, 59, 45);  // inc+dec together ignored
      add(0, 0, 0, 23, 0,  45,  1, 2, 23, 59, 45);
      add(1, 1, 0, 23, 0,  45,  1, 3, 23, 59, 45);  // mode beats inc
      add(0, 0, 0, 23, 0,  45,  1, 3, 23, 59, 45);
      add(0, 1, 0, 23, 0,  45,  1, 3, 23, 59, 46);
      add(0, 0, 0, 23, 0,  45,  1, 3, 23, 59, 46);
      add(1, 0, 0, 23, 0,  45,  0, 0, 23, 59, 46);
      add(0, 0, 0, 31, 60, 63,  0, 0, 23, 59, 46);
      add(1, 0, 0, 31, 60, 63,  1, 1, 0,  0,  0);   // out-of-range preload clamps
      add(0, 0, 0, 31, 60, 63,  1, 1, 0,  0,  0);

      ticks(3);
      chk_all("reset", 0, 1'b0, 0, 0, 0, 0);
      rst_n = 1'b1;

      foreach (vecs[n]) begin
         btn_mode   = vecs[n].m;
         btn_inc    = vecs[n].i;
         btn_dec    = vecs[n].d;
         cur_hour   = vecs[n].ch;
         cur_minute = vecs[n].cm;
         cur_second = vecs[n].cs;
         tick();
         chk_all("vec", n, vecs[n].en, int'(vecs[n].f), int'(vecs[n].h),
                 int'(vecs[n].mi), int'(vecs[n].s));
      end

      wait_idle(0);

      // Timeout with no buttons: 16 cycles after entry.
      btn_mode = 1'b1;
      tick();
      btn_mode = 1'b0;
      ticks(15);
      chk("tmo_plain_hold", 0, int'(set_time_en), 1);
      tick();
      chk("tmo_plain_exit", 0, int'(set_time_en), 0);
      chk("tmo_plain_field", 0, int'(edit_field), 0);

      // Inc edge at cycle 10 restarts the timeout.
      btn_mode = 1'b1;
      tick();
      btn_mode = 1'b0;
      ticks(9);
      btn_inc = 1'b1;
      tick();
      btn_inc = 1'b0;
      ticks(15);
      chk("tmo_post_hold", 0, int'(set_time_en), 1);
      chk("tmo_post_hour", 0, int'(set_time_hour), 1);
      tick();
      chk("tmo_post_exit", 0, int'(set_time_en), 0);

      // Held inc in second field from 57.
      cur_hour   = 5'd10;
      cur_minute = 6'd20;
      cur_second = 6'd57;
      press_mode();
      press_mode();
      press_mode();
      chk("rpt_field", 0, int'(edit_field), 3);
      chk("rpt_start", 0, int'(set_time_second), 57);
      btn_inc = 1'b1;
      tick();
      chk("rpt_edge", 0, int'(set_time_second), 58);
      ticks(7);
      chk("rpt_pre", 0, int'(set_time_second), 58);
      tick();
`ifdef TIME_SET_AUTO_REPEAT_EN
      chk("rpt_first", 0, int'(set_time_second), 59);
      ticks(4);
      chk("rpt_second", 0, int'(set_time_second), 0);
      ticks(4);
      chk("rpt_third", 0, int'(set_time_second), 1);
      chk("rpt_en", 0, int'(set_time_en), 1);
`else
      chk("rpt_first", 0, int'(set_time_second), 58);
      ticks(4);
      chk("rpt_second", 0, int'(set_time_second), 58);
      ticks(4);
      chk("rpt_third", 0, int'(set_time_second), 58);
`endif
      btn_inc = 1'b0;
      tick();
      wait_idle(1);

      // Reset asserted mid-edit returns outputs to reset values immediately.
      btn_mode = 1'b1;
      tick();
      btn_mode = 1'b0;
      chk("mid_en", 0, int'(set_time_en), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("mid_reset", 0, 1'b0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_all("post_reset", 0, 1'b0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/time_set_controller.md
Name:
time_set_controller

Overview:
- Front-panel time-setting initiator; drives the set_time_en / set_time_* interface that the time counters consume.
- Takes debounced mode/inc/dec buttons and steps through hour, minute and second edit fields.
- Preloads the edit values from the live time and applies wrap-around arithmetic per field.
- Reports the active field so the display can blink it.

Parameters:
- TIMEOUT_CYCLES, 1000000, idle cycles with no button edge before the edit is abandoned and the block returns to IDLE; must be >= 2.
- REPEAT_DELAY, 500000, hold cycles before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 100000, cycles between auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- btn_mode  input  1  debounced mode button, active high, synchronous to clk
- btn_inc  input  1  debounced increment button, active high
- btn_dec  input  1  debounced decrement button, active high
- cur_hour  input  5  live hour, 0..23
- cur_minute  input  6  live minute, 0..59
- cur_second  input  6  live second, 0..59
- set_time_en  output  1  high while any field is being edited
- set_time_hour  output  5  edited hour
- set_time_minute  output  6  edited minute
- set_time_second  output  6  edited second
- edit_field  output  2  active field: 0 none, 1 hour, 2 minute, 3 second

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; set_time_en 0; set_time_hour/minute/second 0; edit_field 0; timeout counter 0.
- Button-history registers reset to 1. A button held through reset release therefore produces no edge until it is released and pressed again.
- Edge detect: an edge is btn sampled 1 now while the history register holds 0. The resulting state or value change is visible one clock after the edge sample.
- States and transitions:
  - IDLE -> SET_HOUR on a mode edge; the same edge loads the edit registers from cur_hour, cur_minute and cur_second.
  - SET_HOUR -> SET_MINUTE on a mode edge.
  - SET_MINUTE -> SET_SECOND on a mode edge.
  - SET_SECOND -> IDLE on a mode edge.
  - Any SET_* state -> IDLE on timeout.
- Outputs by state:
  - set_time_en = 1 in SET_* states and 0 in IDLE.
  - edit_field = 1, 2, 3 in SET_HOUR, SET_MINUTE, SET_SECOND; 0 in IDLE.
- set_time_* hold the last edit values in IDLE and are not cleared.
- Inc edge in a SET_* state: the active field +1, wrapping hour 23->0 and minute/second 59->0.
- Dec edge in a SET_* state: the active field -1, wrapping hour 0->23 and minute/second 0->59.
- Out-of-range values never appear. The preload clamps inputs that are out of range: hour >23 loads 0, minute or second >59 loads 0.
- Simultaneous events:
  - inc and dec edges in the same cycle: both ignored.
  - mode edge with inc or dec edge in the same cycle: mode wins, inc/dec ignored.
  - Timeout and mode edge in the same cycle: mode wins.
- Inc/dec edges in IDLE are ignored.
- Timeout counter:
  - Cleared on entry to any SET_* state and on any button edge.
  - Increments each cycle while in a SET_* state.
  - When it reaches TIMEOUT_CYCLES-1, the next clock goes to IDLE and clears the counter.
- Reset asserted mid-edit: immediate return to the reset values.

Optional Feature:
- Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined:
  - Holding inc or dec steadily, with the other button low, in a SET_* state for REPEAT_DELAY cycles after its edge produces one extra step.
  - Further steps follow every REPEAT_PERIOD cycles while the button stays held.
  - Each repeat step clears the timeout counter.
  - Releasing the button, pressing the other button, or any state change cancels repeat.
- Undefined: exactly one step per press; the REPEAT_* parameters are unused.

Test Plan (TIMEOUT_CYCLES=16, REPEAT_DELAY=8, REPEAT_PERIOD=4):
- Reset release with btn_mode held high -> state stays IDLE and set_time_en=0. Release and press again -> SET_HOUR, edit_field=1, and set_time_* equal cur_* (e.g. cur 12:34:56 gives 12/34/56).
- In SET_HOUR with value 23, one inc edge -> 0. Then one dec edge -> 23. In SET_MINUTE with value 0, one dec edge -> 59.
- Three more mode edges from SET_HOUR -> edit_field 2, 3, then 0 with set_time_en=0. set_time_* keep the edited values.
- In SET_MINUTE, inc and dec rise in the same cycle -> minute unchanged. Mode and inc rise together -> SET_SECOND, second unchanged.
- Enter SET_HOUR and apply no buttons -> IDLE and set_time_en=0 after 16 cycles. An inc edge at cycle 10 postpones the exit to 16 cycles after that edge.
- With TIME_SET_AUTO_REPEAT_EN defined, hold inc in SET_SECOND from value 57 for 8+4+4 cycles after the edge -> 58, 59, 0, 1. Without the macro, the value stays 58.
